// File: rtl/scan_table_loader.sv
// Fill stage for the match scanner: loads (row, col, value) triplets into a register table,
// merging duplicate values into their existing slot, and wipes the table one slot per cycle on clear.
module scan_table_loader #(
  parameter int unsigned DEPTH = 9,
  parameter int unsigned W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [W-1:0]                  in_row,
  input  logic [W-1:0]                  in_col,
  input  logic [W-1:0]                  in_value,
  input  logic                          clear,
  output logic [DEPTH*3*W-1:0]          table_flat,
  output logic [DEPTH-1:0]              entry_valid,
  output logic [$clog2(DEPTH+1)-1:0]    count,
  output logic                          full,
  output logic                          load_done
);

  localparam int unsigned SW = 3 * W;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_FULL  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       slot_q [DEPTH];
  logic [SW-1:0]       slot_d [DEPTH];
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CW-1:0]       ptr_q, ptr_d;
  logic                full_q, full_d;
  logic                load_done_q, load_done_d;
  logic                hit;
  logic [CW-1:0]       hit_idx;

  // Ready depends only on state and clear so the source can never see a combinational loop.
  assign in_ready = (state_q == S_FILL) && !clear;

  // Lowest valid slot whose value matches the incoming key.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && (slot_q[i][SW-1 -: W] == in_value)) begin
        hit     = 1'b1;
        hit_idx = CW'(i);
      end
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    valid_d     = valid_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    load_done_d = 1'b0;
    case (state_q)
      S_FILL: begin
        if (clear) begin
          state_d = S_CLEAR;
          count_d = '0;
          ptr_d   = '0;
        end else if (in_valid) begin
          if (hit) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (CW'(i) == hit_idx) slot_d[i] = {in_value, in_col, in_row};
            end
          end else begin
            for (int i = 0; i < DEPTH; i++) begin
              if (CW'(i) == count_q) begin
                slot_d[i]  = {in_value, in_col, in_row};
                valid_d[i] = 1'b1;
              end
            end
            count_d = CW'(count_q + CW'(1));
            if (count_d == CW'(DEPTH)) begin
              state_d     = S_FULL;
              load_done_d = 1'b1;
            end
          end
        end
      end
      S_FULL: begin
        if (clear) begin
          state_d = S_CLEAR;
          count_d = '0;
          ptr_d   = '0;
        end
      end
      S_CLEAR: begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == ptr_q) begin
            slot_d[i]  = '0;
            valid_d[i] = 1'b0;
          end
        end
        if (ptr_q == CW'(DEPTH - 1)) begin
          state_d = S_FILL;
          ptr_d   = '0;
        end else begin
          ptr_d = CW'(ptr_q + CW'(1));
        end
      end
      default: state_d = S_FILL;
    endcase
    full_d = (count_d == CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FILL;
      valid_q     <= '0;
      count_q     <= '0;
      ptr_q       <= '0;
      full_q      <= 1'b0;
      load_done_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      full_q      <= full_d;
      load_done_q <= load_done_d;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) table_flat[i*SW +: SW] = slot_q[i];
  end

  assign entry_valid = valid_q;
  assign count       = count_q;
  assign full        = full_q;
  assign load_done   = load_done_q;

endmodule

// File: tb/tb_scan_table_loader.sv
// Directed bench for scan_table_loader: fill, duplicate merge, backpressure, clear walk and reset.
module tb_scan_table_loader;

  localparam int unsigned DEPTH = 9;
  localparam int unsigned W     = 8;
  localparam int unsigned SW    = 3 * W;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_row;
  logic [W-1:0]         in_col;
  logic [W-1:0]         in_value;
  logic                 clear;
  logic [DEPTH*SW-1:0]  table_flat;
  logic [DEPTH-1:0]     entry_valid;
  logic [3:0]           count;
  logic                 full;
  logic                 load_done;

  int checks = 0;
  int errors = 0;
  logic [DEPTH*SW-1:0] exp_flat;

  scan_table_loader #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_row(in_row), .in_col(in_col), .in_value(in_value),
    .clear(clear),
    .table_flat(table_flat), .entry_valid(entry_valid),
    .count(count), .full(full), .load_done(load_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] r, input logic [7:0] c, input logic [7:0] val);
    in_valid = v;
    in_row   = r;
    in_col   = c;
    in_value = val;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || entry_valid !== 9'd0 || table_flat !== '0) begin
      errors++;
      $display("FAIL reset_state: count=%0d ev=%b flat_nonzero=%0b required 0/0/0", count, entry_valid, |table_flat);
    end
    checks++;
    if (in_ready !== 1'b1 || full !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: in_ready=%b full=%b load_done=%b required 1/0/0", in_ready, full, load_done);
    end
  endtask

  task automatic test_fill();
    int pulses = 0;
    exp_flat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 8'(i), 8'(i + 1), 8'(8'h10 + i));
      exp_flat[i*SW +: SW] = {8'(8'h10 + i), 8'(i + 1), 8'(i)};
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready[%0d]: got %b required 1", i, in_ready);
      end
      step();
      if (load_done === 1'b1) pulses++;
      checks++;
      if (count !== 4'(i + 1) || load_done !== (i == DEPTH - 1)) begin
        errors++;
        $display("FAIL fill_count[%0d]: count=%0d load_done=%b required %0d/%b", i, count, load_done, i + 1, i == DEPTH - 1);
      end
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    checks++;
    if (full !== 1'b1 || entry_valid !== 9'h1FF) begin
      errors++;
      $display("FAIL fill_full: full=%b ev=%b required 1/111111111", full, entry_valid);
    end
    checks++;
    if (table_flat[4*SW +: SW] !== 24'h140504) begin
      errors++;
      $display("FAIL fill_slot4: got %h required 140504", table_flat[4*SW +: SW]);
    end
    checks++;
    if (table_flat !== exp_flat) begin
      errors++;
      $display("FAIL fill_table: got %h required %h", table_flat, exp_flat);
    end
    step();
    if (load_done === 1'b1) pulses++;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL fill_load_done_pulses: got %0d required 1", pulses);
    end
  endtask

  task automatic test_full_backpressure();
    drive(1'b1, 8'h03, 8'h03, 8'hAA);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready[%0d]: got %b required 0", k, in_ready);
      end
      step();
      checks++;
      if (table_flat !== exp_flat || count !== 4'd9 || full !== 1'b1) begin
        errors++;
        $display("FAIL bp_frozen[%0d]: count=%0d full=%b table_changed=%b required 9/1/0", k, count, full, table_flat !== exp_flat);
      end
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_clear();
    logic [8:0] ev_exp;
    clear = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_ready_comb: got %b required 0", in_ready);
    end
    step();
    clear = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || full !== 1'b0 || entry_valid !== 9'h1FF || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_entry: count=%0d full=%b ev=%b ready=%b required 0/0/111111111/0", count, full, entry_valid, in_ready);
    end
    for (int k = 1; k <= DEPTH; k++) begin
      step();
      ev_exp = 9'h1FF << k;
      checks++;
      if (entry_valid !== ev_exp || in_ready !== (k == DEPTH)) begin
        errors++;
        $display("FAIL clear_walk[%0d]: ev=%b ready=%b required %b/%b", k, entry_valid, in_ready, ev_exp, k == DEPTH);
      end
    end
    checks++;
    if (table_flat !== '0 || count !== 4'd0 || full !== 1'b0) begin
      errors++;
      $display("FAIL clear_done: flat_nonzero=%b count=%0d full=%b required 0/0/0", |table_flat, count, full);
    end
  endtask

  task automatic test_duplicate();
    drive(1'b1, 8'h01, 8'h01, 8'h20);
    step();
    drive(1'b1, 8'h07, 8'h03, 8'h20);
    step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    checks++;
    if (count !== 4'd1 || entry_valid !== 9'b1 || table_flat[0 +: SW] !== 24'h200307) begin
      errors++;
      $display("FAIL dup_merge: count=%0d ev=%b slot0=%h required 1/000000001/200307", count, entry_valid, table_flat[0 +: SW]);
    end
    drive(1'b1, 8'h02, 8'h02, 8'h30);
    step();
    drive(1'b1, 8'h09, 8'h09, 8'h20);
    step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    checks++;
    if (count !== 4'd2 || table_flat[0 +: SW] !== 24'h200909 || table_flat[SW +: SW] !== 24'h300202 || table_flat[2*SW +: SW] !== 24'h0) begin
      errors++;
      $display("FAIL dup_second: count=%0d s0=%h s1=%h s2=%h required 2/200909/300202/000000", count,
               table_flat[0 +: SW], table_flat[SW +: SW], table_flat[2*SW +: SW]);
    end
  endtask

  task automatic test_clear_vs_transfer_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'h05, 8'h06, 8'(8'h40 + i));
      step();
    end
    drive(1'b1, 8'h11, 8'h22, 8'h77);
    clear = 1'b1;
    step();
    clear = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    checks++;
    if (count !== 4'd0 || entry_valid !== 9'h03F || table_flat[6*SW +: SW] !== 24'h0) begin
      errors++;
      $display("FAIL clr_vs_xfer: count=%0d ev=%b slot6=%h required 0/000111111/000000", count, entry_valid, table_flat[6*SW +: SW]);
    end
    step();
    step();
    checks++;
    if (entry_valid !== 9'h03C) begin
      errors++;
      $display("FAIL clr_partial: ev=%b required 000111100", entry_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (count !== 4'd0 || entry_valid !== 9'd0 || table_flat !== '0 || in_ready !== 1'b1 || full !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL midclear_reset: count=%0d ev=%b flat_nonzero=%b ready=%b full=%b ld=%b required 0/0/0/1/0/0",
               count, entry_valid, |table_flat, in_ready, full, load_done);
    end
  endtask

  task automatic test_clear_held();
    drive(1'b1, 8'h01, 8'h01, 8'h01);
    step();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    clear = 1'b1;
    for (int k = 0; k <= DEPTH; k++) step();
    checks++;
    if (in_ready !== 1'b0 || entry_valid !== 9'd0) begin
      errors++;
      $display("FAIL held_fill_cycle: ready=%b ev=%b required 0/0", in_ready, entry_valid);
    end
    step();
    clear = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL held_reclear: ready=%b required 0", in_ready);
    end
    for (int k = 0; k < DEPTH - 1; k++) step();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL held_last_clear: ready=%b required 0", in_ready);
    end
    step();
    checks++;
    if (in_ready !== 1'b1 || count !== 4'd0) begin
      errors++;
      $display("FAIL held_back_to_fill: ready=%b count=%0d required 1/0", in_ready, count);
    end
  endtask

  initial begin
    rst   = 1'b1;
    clear = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_fill();
    test_full_backpressure();
    test_clear();
    test_duplicate();
    test_clear_vs_transfer_reset();
    test_clear_held();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
